// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 4-digit 7-segment scan controller
//
// Purpose:
//   Steps a 2-bit digit select across digits 3..0 of a shared 4-bit digit bus.
//   Each digit slot is DIV cycles long. The first BLANK cycles of a slot are dark
//   so the mux can settle without ghosting. The nibble is captured once, at the
//   last dark cycle, and is then decoded and driven for the rest of the slot.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  1 = scanning, 0 = dark with the scan frozen
//   m          in   4  nibble selected by the external digit mux (driven from sel)
//   sel        out  2  digit select, 3 = most significant digit
//   an_n       out  4  active-low digit enables, one-hot when lit
//   seg_n      out  7  active-low segments {g,f,e,d,c,b,a}
//   scan_tick  out  1  one-cycle pulse on the last cycle of every slot
//
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blanking).

module display_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] m,
   output logic [1:0] sel,
   output logic [3:0] an_n,
   output logic [6:0] seg_n,
   output logic       scan_tick
);

   localparam int CW = $clog2(DIV);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_CAP  = CW'(BLANK - 1);
   localparam logic [CW-1:0] CNT_DRV  = CW'(BLANK);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    nib_q, nib_d;
   logic [3:0]    an_n_q, an_n_d;
   logic [6:0]    seg_n_q, seg_n_d;
   logic          tick_q, tick_d;
   logic          lit;

`ifdef LEADING_ZERO_BLANK_EN
   logic          zf_q, zf_d;
`endif

   // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show '-'.
   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Outputs are computed from the next counter/select values so that, once
   // registered, they line up exactly with the cnt range they belong to.
   always_comb begin
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      nib_d   = nib_q;
      tick_d  = 1'b0;
      an_n_d  = 4'hF;
      seg_n_d = 7'h7F;
      lit     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      zf_d    = zf_q;
`endif

      if (en) begin
         // The mux has had the whole dark phase to settle by now.
         if (cnt_q == CNT_CAP) begin
            nib_d = m;
         end
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = sel_q - 2'd1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         tick_d = (cnt_d == CNT_LAST);
         lit    = (cnt_d >= CNT_DRV);
      end else begin
         cnt_d = '0;
      end

`ifdef LEADING_ZERO_BLANK_EN
      // Flag is armed at every (re)start of the most significant slot and
      // dropped by the first nonzero digit of the scan.
      if (en && (cnt_q == CNT_CAP) && (m != 4'd0)) begin
         zf_d = 1'b0;
      end
      if ((cnt_d == '0) && (sel_d == 2'd3)) begin
         zf_d = 1'b1;
      end
      if (zf_d && (nib_d == 4'd0) && (sel_d != 2'd0)) begin
         lit = 1'b0;
      end
`endif

      if (lit) begin
         an_n_d  = ~(4'b0001 << sel_d);
         seg_n_d = ~decode(nib_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         sel_q   <= 2'd3;
         nib_q   <= 4'd0;
         an_n_q  <= 4'hF;
         seg_n_q <= 7'h7F;
         tick_q  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         zf_q    <= 1'b1;
`endif
      end else begin
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         nib_q   <= nib_d;
         an_n_q  <= an_n_d;
         seg_n_q <= seg_n_d;
         tick_q  <= tick_d;
`ifdef LEADING_ZERO_BLANK_EN
         zf_q    <= zf_d;
`endif
      end
   end

   assign sel       = sel_q;
   assign an_n      = an_n_q;
   assign seg_n     = seg_n_q;
   assign scan_tick = tick_q;

endmodule
